// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_package
// Description : Shared AES-128 types, GF(2^8) arithmetic and round functions.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_package;

    // s[c][r] is byte 4*c+r; index [0][0] is the most significant byte.
    typedef logic [0:3][0:3][7:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        KEXP = 2'd2,
        DEC  = 2'd3
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] bb;
        p  = 8'h00;
        x  = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ x;
            x  = xtime(x);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic state_t sub_bytes(input state_t s);
        state_t o;
        for (int i = 0; i < 16; i++) o[2'(i >> 2)][2'(i)] = sbox(s[2'(i >> 2)][2'(i)]);
        return o;
    endfunction

    function automatic state_t inv_sub_bytes(input state_t s);
        state_t o;
        for (int i = 0; i < 16; i++) o[2'(i >> 2)][2'(i)] = inv_sbox(s[2'(i >> 2)][2'(i)]);
        return o;
    endfunction

    function automatic state_t shift_rows(input state_t s);
        state_t     o;
        logic [1:0] c;
        logic [1:0] r;
        for (int i = 0; i < 16; i++) begin
            c = 2'(i >> 2);
            r = 2'(i);
            o[c][r] = s[c + r][r];
        end
        return o;
    endfunction

    function automatic state_t inv_shift_rows(input state_t s);
        state_t     o;
        logic [1:0] c;
        logic [1:0] r;
        for (int i = 0; i < 16; i++) begin
            c = 2'(i >> 2);
            r = 2'(i);
            o[c + r][r] = s[c][r];
        end
        return o;
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t     o;
        logic [1:0] c;
        logic [1:0] r;
        for (int i = 0; i < 16; i++) begin
            c = 2'(i >> 2);
            r = 2'(i);
            o[c][r] = gf_mul(8'h02, s[c][r]) ^ gf_mul(8'h03, s[c][r + 2'd1])
                    ^ s[c][r + 2'd2] ^ s[c][r + 2'd3];
        end
        return o;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t     o;
        logic [1:0] c;
        logic [1:0] r;
        for (int i = 0; i < 16; i++) begin
            c = 2'(i >> 2);
            r = 2'(i);
            o[c][r] = gf_mul(8'h0e, s[c][r]) ^ gf_mul(8'h0b, s[c][r + 2'd1])
                    ^ gf_mul(8'h0d, s[c][r + 2'd2]) ^ gf_mul(8'h09, s[c][r + 2'd3]);
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_interface.sv
`default_nettype none
// ============================================================================
// Module      : aes_interface
// Description : Signal bundle for the AES-128 engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_interface (
    input logic clk,
    input logic rst
);
    logic         start_encryption;
    logic         start_decryption;
    logic [127:0] plaintext_encryption;
    logic [127:0] key_encryption;
    logic [127:0] cyphertext_decryption;
    logic [127:0] cyphertext_encryption;
    logic         done_encryption;
    logic [127:0] plaintext_decryption;
    logic         done_decyption;

    modport dut (
        input  clk, rst, start_encryption, start_decryption,
        input  plaintext_encryption, key_encryption, cyphertext_decryption,
        output cyphertext_encryption, done_encryption, plaintext_decryption, done_decyption
    );
endinterface
`default_nettype wire

// File: rtl/aes_key_step.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_step
// Description : One forward (i_dir=0) or inverse (i_dir=1) AES-128 key step.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_step
    import aes_package::*;
(
    input  logic [127:0] i_rk,
    input  logic [7:0]   i_rcon,
    input  logic         i_dir,
    output logic [127:0] o_rk
);
    logic [31:0] w_w0, w_w1, w_w2, w_w3, w_t, w_g, w_n0, w_n1, w_n2;

    assign {w_w0, w_w1, w_w2, w_w3} = i_rk;

    // The inverse step recovers the previous last word as w3^w2, so one SubWord serves both.
    assign w_t  = i_dir ? (w_w3 ^ w_w2) : w_w3;
    assign w_g  = {sbox(w_t[23:16]), sbox(w_t[15:8]), sbox(w_t[7:0]), sbox(w_t[31:24])}
                ^ {i_rcon, 24'h000000};
    assign w_n0 = w_w0 ^ w_g;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;

    assign o_rk = i_dir ? {w_n0, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2}
                        : {w_n0, w_n1, w_n2, w_w3 ^ w_n2};
endmodule
`default_nettype wire

// File: rtl/aes.sv
`default_nettype none
// ============================================================================
// Module      : aes
// Description : Iterative AES-128 encrypt/decrypt engine, one round per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module aes (
    aes_interface.dut intf
);
    import aes_package::*;

    fsm_t         r_fsm, w_fsm_next;
    logic [127:0] r_state, r_rk, r_ct_out, r_pt_out;
    logic [127:0] w_rk_step, w_enc_next, w_dec_next;
    state_t       w_enc_sr, w_dec_add;
    logic [3:0]   r_round;
    logic [7:0]   w_rcon;
    logic         w_inv;
    logic         r_done_enc, r_done_dec;

    assign w_rcon = rcon(r_round);
    assign w_inv  = (r_fsm == DEC);

    aes_key_step u_key_step (
        .i_rk   (r_rk),
        .i_rcon (w_rcon),
        .i_dir  (w_inv),
        .o_rk   (w_rk_step)
    );

    always_comb begin
        w_enc_sr   = shift_rows(sub_bytes(r_state));
        w_enc_next = ((r_round == 4'd10) ? w_enc_sr : mix_columns(w_enc_sr)) ^ w_rk_step;
        w_dec_add  = inv_sub_bytes(inv_shift_rows(r_state)) ^ w_rk_step;
        w_dec_next = (r_round == 4'd1) ? w_dec_add : inv_mix_columns(w_dec_add);
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            IDLE: begin
                if (intf.start_encryption)      w_fsm_next = ENC;
                else if (intf.start_decryption) w_fsm_next = KEXP;
            end
            ENC:     if (r_round == 4'd11) w_fsm_next = IDLE;
            KEXP:    if (r_round == 4'd10) w_fsm_next = DEC;
            DEC:     if (r_round == 4'd0)  w_fsm_next = IDLE;
            default: w_fsm_next = IDLE;
        endcase
    end

    // Round counts up 1..11 for encryption/key expansion and down 10..0 for decryption;
    // the extra count in each direction is the output-register cycle.
    always_ff @(posedge intf.clk or posedge intf.rst) begin
        if (intf.rst) begin
            r_fsm      <= IDLE;
            r_state    <= '0;
            r_rk       <= '0;
            r_round    <= '0;
            r_ct_out   <= '0;
            r_pt_out   <= '0;
            r_done_enc <= 1'b0;
            r_done_dec <= 1'b0;
        end else begin
            r_fsm <= w_fsm_next;
            case (r_fsm)
                IDLE: begin
                    if (intf.start_encryption) begin
                        r_state    <= intf.plaintext_encryption ^ intf.key_encryption;
                        r_rk       <= intf.key_encryption;
                        r_round    <= 4'd1;
                        r_done_enc <= 1'b0;
                    end else if (intf.start_decryption) begin
                        r_state    <= intf.cyphertext_decryption;
                        r_rk       <= intf.key_encryption;
                        r_round    <= 4'd1;
                        r_done_dec <= 1'b0;
                    end
                end
                ENC: begin
                    if (r_round == 4'd11) begin
                        r_ct_out   <= r_state;
                        r_done_enc <= 1'b1;
                    end else begin
                        r_state <= w_enc_next;
                        r_rk    <= w_rk_step;
                        r_round <= r_round + 4'd1;
                    end
                end
                KEXP: begin
                    r_rk <= w_rk_step;
                    if (r_round == 4'd10) r_state <= r_state ^ w_rk_step;
                    else                  r_round <= r_round + 4'd1;
                end
                DEC: begin
                    if (r_round == 4'd0) begin
                        r_pt_out   <= r_state;
                        r_done_dec <= 1'b1;
                    end else begin
                        r_state <= w_dec_next;
                        r_rk    <= w_rk_step;
                        r_round <= r_round - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign intf.cyphertext_encryption = r_ct_out;
    assign intf.done_encryption       = r_done_enc;
    assign intf.plaintext_decryption  = r_pt_out;
    assign intf.done_decyption        = r_done_dec;
endmodule
`default_nettype wire

// File: tb/tb_aes.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes
// Description : Directed and random checks of the aes engine against a table-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_interface intf (.clk(clk), .rst(rst));
    aes dut (.intf(intf));

    int n_cmp = 0;
    int n_err = 0;

    typedef logic [7:0] blk_t [16];
    logic [7:0] alog [256];
    logic [7:0] lg   [256];
    logic [7:0] sb   [256];
    logic [7:0] isb  [256];

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return alog[(int'(lg[a]) + int'(lg[b])) % 255];
    endfunction

    // S-boxes from log/antilog tables over generator 3 plus the FIPS-197 affine map.
    task automatic build_tables();
        logic [7:0] x, inv, b, cc;
        cc = 8'h63;
        x  = 8'h01;
        for (int i = 0; i < 255; i++) begin
            alog[i] = x;
            lg[x]   = 8'(i);
            x       = x ^ xt(x);
        end
        for (int v = 0; v < 256; v++) begin
            inv = (v == 0) ? 8'h00 : alog[(255 - int'(lg[v])) % 255];
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                     ^ inv[(i + 7) % 8] ^ cc[i];
            sb[v]  = b;
            isb[b] = 8'(v);
        end
    endtask

    function automatic blk_t to_blk(input logic [127:0] x);
        blk_t b;
        for (int n = 0; n < 16; n++) b[n] = x[127 - 8 * n -: 8];
        return b;
    endfunction

    function automatic logic [127:0] from_blk(input blk_t b);
        logic [127:0] x;
        for (int n = 0; n < 16; n++) x[127 - 8 * n -: 8] = b[n];
        return x;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] key);
        blk_t s, t;
        logic [7:0] a [4];
        s = to_blk(pt ^ round_key(key, 0));
        for (int r = 1; r <= 10; r++) begin
            for (int n = 0; n < 16; n++) t[n] = sb[s[n]];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) s[4 * c + j] = t[4 * ((c + j) % 4) + j];
            if (r < 10)
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = s[4 * c + j];
                    for (int j = 0; j < 4; j++)
                        s[4 * c + j] = mul(8'h02, a[j]) ^ mul(8'h03, a[(j + 1) % 4])
                                     ^ a[(j + 2) % 4] ^ a[(j + 3) % 4];
                end
            s = to_blk(from_blk(s) ^ round_key(key, r));
        end
        return from_blk(s);
    endfunction

    function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic [127:0] key);
        blk_t s, t;
        logic [7:0] a [4];
        s = to_blk(ct ^ round_key(key, 10));
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) t[4 * ((c + j) % 4) + j] = s[4 * c + j];
            for (int n = 0; n < 16; n++) s[n] = isb[t[n]];
            s = to_blk(from_blk(s) ^ round_key(key, r));
            if (r > 0)
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = s[4 * c + j];
                    for (int j = 0; j < 4; j++)
                        s[4 * c + j] = mul(8'h0e, a[j]) ^ mul(8'h0b, a[(j + 1) % 4])
                                     ^ mul(8'h0d, a[(j + 2) % 4]) ^ mul(8'h09, a[(j + 3) % 4]);
                end
        end
        return from_blk(s);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit dec, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!(dec ? intf.done_decyption : intf.done_encryption) && lat < 40);
    endtask

    task automatic run_enc(input string tag, input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp);
        int lat;
        @(negedge clk);
        intf.plaintext_encryption = pt;
        intf.key_encryption       = key;
        intf.start_encryption     = 1'b1;
        @(posedge clk);
        #1;
        intf.start_encryption     = 1'b0;
        intf.plaintext_encryption = rand128();
        intf.key_encryption       = rand128();
        check({tag, " done cleared"}, 128'(intf.done_encryption), 128'd0);
        wait_done(1'b0, lat);
        check({tag, " latency"}, 128'(lat), 128'd11);
        check({tag, " result"}, intf.cyphertext_encryption, exp);
    endtask

    task automatic run_dec(input string tag, input logic [127:0] ct, input logic [127:0] key,
                           input logic [127:0] exp);
        int lat;
        @(negedge clk);
        intf.cyphertext_decryption = ct;
        intf.key_encryption        = key;
        intf.start_decryption      = 1'b1;
        @(posedge clk);
        #1;
        intf.start_decryption      = 1'b0;
        intf.cyphertext_decryption = rand128();
        intf.key_encryption        = rand128();
        check({tag, " done cleared"}, 128'(intf.done_decyption), 128'd0);
        wait_done(1'b1, lat);
        check({tag, " latency"}, 128'(lat), 128'd21);
        check({tag, " result"}, intf.plaintext_decryption, exp);
    endtask

    initial begin
        logic [127:0] k, p, c, pd;
        int lat;
        build_tables();
        intf.start_encryption      = 1'b0;
        intf.start_decryption      = 1'b0;
        intf.plaintext_encryption  = '0;
        intf.key_encryption        = '0;
        intf.cyphertext_decryption = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset ct", intf.cyphertext_encryption, 128'd0);
        check("reset done_enc", 128'(intf.done_encryption), 128'd0);
        check("reset pt", intf.plaintext_decryption, 128'd0);
        check("reset done_dec", 128'(intf.done_decyption), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        run_enc("fips enc", 128'h00112233445566778899aabbccddeeff,
                128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        run_dec("fips dec", 128'h3925841d02dc09fbdc118597196a0b32,
                128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734);

        p = 128'h00000101030307070f0f1f1f3f3f7f7f;
        run_enc("zero-key enc", p, 128'd0, model_enc(p, 128'd0));
        c = intf.cyphertext_encryption;
        run_dec("zero-key roundtrip", c, 128'd0, p);

        run_enc("zero vector", 128'd0, 128'd0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

        // Start pulses while busy must be ignored.
        @(negedge clk);
        intf.plaintext_encryption = 128'd0;
        intf.key_encryption       = 128'd0;
        intf.start_encryption     = 1'b1;
        @(posedge clk);
        #1;
        intf.start_encryption = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        intf.plaintext_encryption = rand128();
        intf.start_encryption     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        intf.start_encryption = 1'b0;
        wait_done(1'b0, lat);
        check("busy start latency", 128'(lat), 128'd6);
        check("busy start result", intf.cyphertext_encryption, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

        for (int i = 0; i < 3; i++) begin
            k = rand128();
            p = rand128();
            c = rand128();
            run_enc("random enc", p, k, model_enc(p, k));
            run_dec("random dec", c, k, model_dec(c, k));
        end

        // Asynchronous reset in the middle of round 5.
        @(negedge clk);
        intf.plaintext_encryption = rand128();
        intf.key_encryption       = rand128();
        intf.start_encryption     = 1'b1;
        @(posedge clk);
        #1;
        intf.start_encryption = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort ct", intf.cyphertext_encryption, 128'd0);
        check("abort done_enc", 128'(intf.done_encryption), 128'd0);
        check("abort pt", intf.plaintext_decryption, 128'd0);
        check("abort done_dec", 128'(intf.done_decyption), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        k = rand128();
        p = rand128();
        run_enc("post-reset enc", p, k, model_enc(p, k));

        // Simultaneous starts: encryption wins, prior decryption result is untouched.
        c = rand128();
        pd = model_dec(c, k);
        run_dec("pre-both dec", c, k, pd);
        p = rand128();
        k = rand128();
        @(negedge clk);
        intf.plaintext_encryption  = p;
        intf.key_encryption        = k;
        intf.cyphertext_decryption = rand128();
        intf.start_encryption      = 1'b1;
        intf.start_decryption      = 1'b1;
        @(posedge clk);
        #1;
        intf.start_encryption = 1'b0;
        intf.start_decryption = 1'b0;
        wait_done(1'b0, lat);
        check("both latency", 128'(lat), 128'd11);
        check("both enc result", intf.cyphertext_encryption, model_enc(p, k));
        check("both done_dec kept", 128'(intf.done_decyption), 128'd1);
        check("both pt kept", intf.plaintext_decryption, pd);
        repeat (25) @(posedge clk);
        #1;
        check("later done_dec kept", 128'(intf.done_decyption), 128'd1);
        check("later pt kept", intf.plaintext_decryption, pd);
        check("later done_enc sticky", 128'(intf.done_encryption), 128'd1);

        // Start held high restarts on return to IDLE.
        p = rand128();
        k = rand128();
        @(negedge clk);
        intf.plaintext_encryption = p;
        intf.key_encryption       = k;
        intf.start_encryption     = 1'b1;
        @(posedge clk);
        #1;
        wait_done(1'b0, lat);
        check("held latency", 128'(lat), 128'd11);
        check("held result", intf.cyphertext_encryption, model_enc(p, k));
        @(posedge clk);
        #1;
        check("held restart clears done", 128'(intf.done_encryption), 128'd0);
        intf.start_encryption = 1'b0;
        wait_done(1'b0, lat);
        check("held restart latency", 128'(lat), 128'd11);
        check("held restart result", intf.cyphertext_encryption, model_enc(p, k));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
